writeback_queue: RTL

Write-side companion to the 8x8-bit register file: buffers register writeback requests from the datapath and commits them to the register file one per cycle via its Write_Reg_Num / Write_Data / RegWrite inputs. It provides a DEPTH-entry FIFO with valid/ready acceptance, a hold input for stalling commits, and two combinational bypass lookups. The bypass lookups let operand-read logic see values that are still queued or in flight and not yet in the register file.

---
 rtl/writeback_queue_if.sv | 34 +++
 rtl/writeback_queue.sv | 97 +++++++++
 2 files changed

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: request, commit, bypass and status signals of the writeback queue
interface writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic              In_Valid;
  logic              In_Ready;
  logic [ADDR_W-1:0] In_Reg_Num;
  logic [DATA_W-1:0] In_Data;
  logic              Drain_Hold;
  logic [ADDR_W-1:0] Write_Reg_Num;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Lookup_Reg_Num1;
  logic [ADDR_W-1:0] Lookup_Reg_Num2;
  logic              Bypass_Hit1;
  logic              Bypass_Hit2;
  logic [DATA_W-1:0] Bypass_Data1;
  logic [DATA_W-1:0] Bypass_Data2;
  logic [OCC_W-1:0]  Occupancy;
  logic              Idle;
  modport slave (
    input  In_Valid, In_Reg_Num, In_Data, Drain_Hold, Lookup_Reg_Num1, Lookup_Reg_Num2,
    output In_Ready, Write_Reg_Num, Write_Data, RegWrite, Bypass_Hit1, Bypass_Hit2,
           Bypass_Data1, Bypass_Data2, Occupancy, Idle
  );
  modport master (
    output In_Valid, In_Reg_Num, In_Data, Drain_Hold, Lookup_Reg_Num1, Lookup_Reg_Num2,
    input  In_Ready, Write_Reg_Num, Write_Data, RegWrite, Bypass_Hit1, Bypass_Hit2,
           Bypass_Data1, Bypass_Data2, Occupancy, Idle
  );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: FIFO of register writebacks committed one per cycle, with operand bypass lookups
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic              Clk,
  input logic              Reset,
  writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] reg_q [DEPTH];
  logic [ADDR_W-1:0] reg_d [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DATA_W-1:0] dat_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regwrite_q, regwrite_d;
  logic              full, push, pop;
  logic [1:0][ADDR_W-1:0] lk;
  logic [1:0]             hit;
  logic [1:0][DATA_W-1:0] bdat;
  assign full = occ_q == OCC_W'(DEPTH);
  assign bus.In_Ready = !full && Reset;
  // register 0 requests complete the handshake but are dropped
  assign push = bus.In_Valid && bus.In_Ready && bus.In_Reg_Num != '0;
  assign pop  = occ_q != '0 && !bus.Drain_Hold;
  always_comb begin
    reg_d = reg_q;
    dat_d = dat_q;
    if (push) begin
      reg_d[wr_ptr_q] = bus.In_Reg_Num;
      dat_d[wr_ptr_q] = bus.In_Data;
    end
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
    regwrite_d = pop;
    wreg_d     = pop ? reg_q[rd_ptr_q] : wreg_q;
    wdata_d    = pop ? dat_q[rd_ptr_q] : wdata_q;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      reg_q      <= '{default: '0};
      dat_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      reg_q      <= reg_d;
      dat_q      <= dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
    end
  end
  assign lk[0] = bus.Lookup_Reg_Num1;
  assign lk[1] = bus.Lookup_Reg_Num2;
  // search oldest to youngest so later matches override; output stage has lowest priority
  always_comb begin
    hit  = '0;
    bdat = '0;
    for (int p = 0; p < 2; p++) begin
      if (regwrite_q && wreg_q == lk[p]) begin
        hit[p]  = 1'b1;
        bdat[p] = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++)
        if (OCC_W'(i) < occ_q && reg_q[rd_ptr_q + PTR_W'(i)] == lk[p]) begin
          hit[p]  = 1'b1;
          bdat[p] = dat_q[rd_ptr_q + PTR_W'(i)];
        end
      if (lk[p] == '0) begin
        hit[p]  = 1'b0;
        bdat[p] = '0;
      end
    end
  end
  assign bus.Write_Reg_Num = wreg_q;
  assign bus.Write_Data    = wdata_q;
  assign bus.RegWrite      = regwrite_q;
  assign bus.Bypass_Hit1   = hit[0];
  assign bus.Bypass_Hit2   = hit[1];
  assign bus.Bypass_Data1  = bdat[0];
  assign bus.Bypass_Data2  = bdat[1];
  assign bus.Occupancy     = occ_q;
  assign bus.Idle          = occ_q == '0 && !regwrite_q;
endmodule
